// File: rtl/dino_jump_ctrl.sv
// Dinosaur jump controller: integer jump physics on a divided tick plus posture.
// Optional fast fall while ducking is enabled by defining DINO_FAST_FALL_EN.
module dino_jump_ctrl #(
    parameter int GROUND   = 298,
    parameter int JUMP_VEL = 12,
    parameter int GRAVITY  = 1,
    parameter int TICK_DIV = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       jump_key,
    input  logic       duck_key,
    input  logic [1:0] game_state,
    output logic [9:0] pos,
    output logic       dino_behavior,
    output logic       airborne,
    output logic       land_pulse,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ST_GROUND  = 2'd0,
        ST_RISING  = 2'd1,
        ST_FALLING = 2'd2
    } state_t;

    localparam logic [1:0] GS_INIT  = 2'd0;
    localparam logic [1:0] GS_END   = 2'd2;
    localparam logic [1:0] GS_RESET = 2'd3;

    localparam int            CW        = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [9:0]    GND       = 10'(GROUND);
    localparam logic [6:0]    VJUMP     = 7'(JUMP_VEL);
    localparam logic [6:0]    GRV       = 7'(GRAVITY);

    logic [CW-1:0] r_cnt;
    state_t        r_state;
    logic [9:0]    r_pos;
    logic [6:0]    r_vel;
    logic          r_key_q;
    logic          r_jump_pend;
    logic          r_behav;
    logic          r_airborne;
    logic          r_land_pulse;

    logic          w_tick;
    logic          w_soft_rst;
    logic          w_start;
    logic          w_key_edge;
    logic          w_launch;
    logic [7:0]    w_g;
    logic [7:0]    w_vsum;
    logic [6:0]    w_vsat;
    logic [10:0]   w_pos_sum;
    logic [9:0]    w_rise_pos;

    assign w_tick     = (r_cnt == TICK_LAST);
    assign w_soft_rst = rst || (game_state == GS_RESET);
    assign w_start    = (game_state != GS_INIT) && (game_state != GS_END);
    assign w_key_edge = w_start && jump_key && !r_key_q;
    assign w_launch   = w_start && w_tick && (r_state == ST_GROUND) && r_jump_pend;

`ifdef DINO_FAST_FALL_EN
    assign w_g = duck_key ? 8'(2 * GRAVITY) : {1'b0, GRV};
`else
    assign w_g = {1'b0, GRV};
`endif

    // Landing test uses the unsaturated velocity; only the stored copy saturates.
    assign w_vsum     = {1'b0, r_vel} + w_g;
    assign w_vsat     = w_vsum[7] ? 7'h7f : w_vsum[6:0];
    assign w_pos_sum  = {1'b0, r_pos} + {3'b000, w_vsum};
    assign w_rise_pos = ({3'b000, r_vel} > r_pos) ? 10'd0 : (r_pos - {3'b000, r_vel});

    // The tick counter only answers to rst, never to the RESET game state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_soft_rst) begin
            r_state      <= ST_GROUND;
            r_pos        <= GND;
            r_vel        <= '0;
            r_key_q      <= 1'b0;
            r_jump_pend  <= 1'b0;
            r_behav      <= 1'b1;
            r_airborne   <= 1'b0;
            r_land_pulse <= 1'b0;
        end else begin
            r_key_q      <= jump_key;
            r_land_pulse <= 1'b0;
            case (game_state)
                GS_INIT: begin
                    r_state     <= ST_GROUND;
                    r_pos       <= GND;
                    r_vel       <= '0;
                    r_jump_pend <= 1'b0;
                    r_behav     <= 1'b1;
                    r_airborne  <= 1'b0;
                end
                GS_END: begin
                    if (w_tick) begin
                        r_jump_pend <= 1'b0;
                    end
                end
                default: begin
                    // An edge arriving on a tick is kept for the following tick.
                    if (w_tick) begin
                        r_jump_pend <= w_key_edge;
                    end else begin
                        r_jump_pend <= r_jump_pend | w_key_edge;
                    end
                    r_behav <= !((r_state == ST_GROUND) && duck_key && !w_launch);
                    if (w_tick) begin
                        case (r_state)
                            ST_GROUND: begin
                                if (r_jump_pend) begin
                                    r_state    <= ST_RISING;
                                    r_vel      <= VJUMP;
                                    r_airborne <= 1'b1;
                                end
                            end
                            ST_RISING: begin
                                r_pos <= w_rise_pos;
                                if (r_vel <= GRV) begin
                                    r_vel   <= '0;
                                    r_state <= ST_FALLING;
                                end else begin
                                    r_vel <= r_vel - GRV;
                                end
                            end
                            ST_FALLING: begin
                                if (w_pos_sum >= {1'b0, GND}) begin
                                    r_pos        <= GND;
                                    r_vel        <= '0;
                                    r_state      <= ST_GROUND;
                                    r_airborne   <= 1'b0;
                                    r_land_pulse <= 1'b1;
                                end else begin
                                    r_pos <= w_pos_sum[9:0];
                                    r_vel <= w_vsat;
                                end
                            end
                            default: begin
                                r_state <= ST_GROUND;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign pos           = r_pos;
    assign dino_behavior = r_behav;
    assign airborne      = r_airborne;
    assign land_pulse    = r_land_pulse;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Directed bench for dino_jump_ctrl with a 4-cycle physics tick.
// Expected positions are hand-computed from the jump physics.
module tb_dino_jump_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       jump_key;
    logic       duck_key;
    logic [1:0] game_state;
    logic [9:0] pos;
    logic       dino_behavior;
    logic       airborne;
    logic       land_pulse;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int land_cnt = 0;
    int tb_cnt   = 0;

    dino_jump_ctrl #(
        .GROUND  (298),
        .JUMP_VEL(12),
        .GRAVITY (1),
        .TICK_DIV(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .jump_key     (jump_key),
        .duck_key     (duck_key),
        .game_state   (game_state),
        .pos          (pos),
        .dino_behavior(dino_behavior),
        .airborne     (airborne),
        .land_pulse   (land_pulse),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    // Bench-side view of the physics tick: a tick edge follows a count of 3.
    always @(posedge clk) begin
        if (rst) tb_cnt <= 0;
        else     tb_cnt <= (tb_cnt == 3) ? 0 : tb_cnt + 1;
    end

    always @(negedge clk) begin
        if (land_pulse) land_cnt <= land_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance past n tick edges, sampling just after the last one.
    task automatic wait_ticks(input int n);
        repeat (n) begin
            while (tb_cnt != 3) step(1);
            step(1);
        end
    endtask

    task automatic press_jump();
        jump_key = 1'b1;
        step(1);
        jump_key = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        jump_key   = 1'b0;
        duck_key   = 1'b0;
        game_state = 2'd1;
        step(3);
        rst = 1'b0;
        check("reset_pos", 32'(pos), 32'd298);
        check("reset_behav", 32'(dino_behavior), 32'd1);
        check("reset_air", 32'(airborne), 32'd0);
        check("reset_land", 32'(land_pulse), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);

        wait_ticks(10);
        check("idle_pos", 32'(pos), 32'd298);
        check("idle_air", 32'(airborne), 32'd0);
        check("idle_behav", 32'(dino_behavior), 32'd1);
        check("idle_land_cnt", 32'(land_cnt), 32'd0);

        // Basic jump trajectory
        press_jump();
        wait_ticks(1);
        check("launch_air", 32'(airborne), 32'd1);
        check("launch_pos", 32'(pos), 32'd298);
        wait_ticks(1);
        check("rise_t1", 32'(pos), 32'd286);
        wait_ticks(1);
        check("rise_t2", 32'(pos), 32'd275);
        wait_ticks(1);
        check("rise_t3", 32'(pos), 32'd265);
        wait_ticks(9);
        check("apex_pos", 32'(pos), 32'd220);
        check("apex_state", 32'(dbg_state), 32'd2);
        wait_ticks(11);
        check("fall_t11", 32'(pos), 32'd286);
        check("fall_no_land", 32'(land_pulse), 32'd0);
        wait_ticks(1);
        check("land_pos", 32'(pos), 32'd298);
        check("land_pulse", 32'(land_pulse), 32'd1);
        check("land_air", 32'(airborne), 32'd0);
        step(1);
        check("land_pulse_off", 32'(land_pulse), 32'd0);

        // Held key gives exactly one jump; a fresh press gives another
        jump_key = 1'b1;
        step(1);
        wait_ticks(1);
        check("hold_launch", 32'(airborne), 32'd1);
        wait_ticks(24);
        check("hold_land_pos", 32'(pos), 32'd298);
        check("hold_land_air", 32'(airborne), 32'd0);
        wait_ticks(10);
        check("hold_no_retrig", 32'(airborne), 32'd0);
        jump_key = 1'b0;
        step(1);
        press_jump();
        wait_ticks(1);
        check("second_launch", 32'(airborne), 32'd1);
        wait_ticks(24);
        check("second_land", 32'(pos), 32'd298);

        // Ducking, jump while ducking, duck in the air
        duck_key = 1'b1;
        step(1);
        check("duck_behav", 32'(dino_behavior), 32'd0);
        press_jump();
        check("duck_pend_behav", 32'(dino_behavior), 32'd0);
        wait_ticks(1);
        check("duck_launch_behav", 32'(dino_behavior), 32'd1);
        check("duck_launch_air", 32'(airborne), 32'd1);
        wait_ticks(3);
        check("air_duck_behav", 32'(dino_behavior), 32'd1);
        check("air_duck_pos", 32'(pos), 32'd265);
        wait_ticks(9);
        check("duck_apex", 32'(pos), 32'd220);
`ifdef DINO_FAST_FALL_EN
        wait_ticks(1);
        check("fast_t1", 32'(pos), 32'd222);
        wait_ticks(1);
        check("fast_t2", 32'(pos), 32'd226);
        wait_ticks(7);
`else
        wait_ticks(1);
        check("slow_t1", 32'(pos), 32'd221);
        wait_ticks(11);
`endif
        check("duck_land_pos", 32'(pos), 32'd298);
        check("duck_land_pulse", 32'(land_pulse), 32'd1);
        check("duck_land_behav", 32'(dino_behavior), 32'd1);
        step(1);
        check("duck_after_land", 32'(dino_behavior), 32'd0);
        duck_key = 1'b0;
        step(1);
        check("unduck_behav", 32'(dino_behavior), 32'd1);

        // END freezes mid-jump, RESET restores the rest position
        press_jump();
        wait_ticks(1);
        wait_ticks(5);
        check("pre_end_pos", 32'(pos), 32'd248);
        game_state = 2'd2;
        wait_ticks(100);
        check("end_pos", 32'(pos), 32'd248);
        check("end_air", 32'(airborne), 32'd1);
        check("end_state", 32'(dbg_state), 32'd1);
        game_state = 2'd3;
        step(1);
        check("greset_pos", 32'(pos), 32'd298);
        check("greset_air", 32'(airborne), 32'd0);
        check("greset_behav", 32'(dino_behavior), 32'd1);
        game_state = 2'd1;
        step(1);

        // INIT ignores keys
        game_state = 2'd0;
        jump_key   = 1'b1;
        duck_key   = 1'b1;
        wait_ticks(3);
        check("init_air", 32'(airborne), 32'd0);
        check("init_pos", 32'(pos), 32'd298);
        check("init_behav", 32'(dino_behavior), 32'd1);
        jump_key   = 1'b0;
        duck_key   = 1'b0;
        game_state = 2'd1;
        step(1);

        // rst mid-jump
        press_jump();
        wait_ticks(1);
        wait_ticks(3);
        check("pre_rst_pos", 32'(pos), 32'd265);
        rst = 1'b1;
        step(1);
        check("rst_pos", 32'(pos), 32'd298);
        check("rst_air", 32'(airborne), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        step(2);

        check("land_count", 32'(land_cnt), 32'd4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
